// File: rtl/reg_bus_master.sv
// Register-bus initiator: turns a valid/ready command byte stream into
// reg_address/reg_bytecnt/reg_read/reg_write transactions and streams read bytes back.
`timescale 1ns/1ps

// state        | meaning
// S_IDLE       | waiting for the address byte
// S_HDR        | waiting for the control byte (direction + length)
// S_WR_DATA    | accepting write data, one strobe per accepted byte
// S_WR_END     | one-cycle tail after the last write strobe
// S_RD_STROBE  | single-cycle reg_read pulse for the current index
// S_RD_CAPTURE | registering read_data into the response slot
// S_RD_WAIT    | holding the response until the consumer accepts it
module reg_bus_master #(
    parameter int pBYTECNT_SIZE = 7
) (
    input  logic                     cwusb_clk,
    input  logic                     reset_n,
    input  logic [7:0]               cmd_data,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    output logic [7:0]               rsp_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               write_data,
    input  logic [7:0]               read_data,
    output logic                     reg_read,
    output logic                     reg_write,
    output logic                     reg_addrvalid,
    output logic                     busy
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_HDR        = 3'd1;
    localparam logic [2:0] S_WR_DATA    = 3'd2;
    localparam logic [2:0] S_WR_END     = 3'd3;
    localparam logic [2:0] S_RD_STROBE  = 3'd4;
    localparam logic [2:0] S_RD_CAPTURE = 3'd5;
    localparam logic [2:0] S_RD_WAIT    = 3'd6;

    logic [2:0] state;
    logic [6:0] len;
    logic [6:0] idx;
    logic       wr_first;
    logic       cmd_hs;
    logic       rsp_hs;
    logic       wr_last;

    assign cmd_ready     = reset_n && ((state == S_IDLE) || (state == S_HDR) || (state == S_WR_DATA));
    assign cmd_hs        = cmd_valid && cmd_ready;
    assign rsp_hs        = rsp_valid && rsp_ready;
    assign reg_read      = (state == S_RD_STROBE);
    assign reg_addrvalid = (state != S_IDLE) && (state != S_HDR);
    assign busy          = (state != S_IDLE);
    assign reg_bytecnt   = pBYTECNT_SIZE'(idx);

    // idx holds the index of the byte currently on the bus, so the first write keeps it at 0
    assign wr_last = wr_first ? (len == 7'd0) : ((idx + 7'd1) == len);

    always_ff @(posedge cwusb_clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            len         <= 7'd0;
            idx         <= 7'd0;
            wr_first    <= 1'b0;
            reg_address <= 8'h00;
            write_data  <= 8'h00;
            reg_write   <= 1'b0;
            rsp_data    <= 8'h00;
            rsp_valid   <= 1'b0;
        end else begin
            reg_write <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_hs) begin
                        reg_address <= cmd_data;
                        state       <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (cmd_hs) begin
                        len      <= cmd_data[6:0];
                        idx      <= 7'd0;
                        wr_first <= 1'b1;
                        state    <= cmd_data[7] ? S_RD_STROBE : S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (cmd_hs) begin
                        write_data <= cmd_data;
                        reg_write  <= 1'b1;
                        wr_first   <= 1'b0;
                        if (!wr_first) begin
                            idx <= idx + 7'd1;
                        end
                        if (wr_last) begin
                            state <= S_WR_END;
                        end
                    end
                end
                S_WR_END: begin
                    state <= S_IDLE;
                end
                S_RD_STROBE: begin
                    state <= S_RD_CAPTURE;
                end
                S_RD_CAPTURE: begin
                    rsp_data  <= read_data;
                    rsp_valid <= 1'b1;
                    state     <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (rsp_hs) begin
                        rsp_valid <= 1'b0;
                        if (idx == len) begin
                            state <= S_IDLE;
                        end else begin
                            idx   <= idx + 7'd1;
                            state <= S_RD_STROBE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
